// File: rtl/snitch_icache_tag_ctrl.sv
// rtl/snitch_icache_tag_ctrl.sv - icache tag store: per-way tag SRAMs behind a request port with an init/flush sweep engine
module snitch_icache_tag_sram #(
  parameter int unsigned WIDTH      = 39,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter type         cfg_t      = logic
) (
  input  logic                  clk,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  cfg_t                  cfg,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Behavioural macro stand-in; the config only matters to real SRAM macros.
  logic cfg_unused;
  assign cfg_unused = ^cfg;

  always_ff @(posedge clk) begin
    if (req) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

module snitch_icache_tag_ctrl #(
  parameter int unsigned SET_COUNT      = 2,
  parameter int unsigned LINE_COUNT     = 128,
  parameter int unsigned TAG_WIDTH      = 37,
  parameter bit          OUT_REG        = 1'b0,
  parameter type         sram_cfg_tag_t = logic,
  parameter int unsigned ADDR_WIDTH     = $clog2(LINE_COUNT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  sram_cfg_tag_t                        sram_cfg_tag_i,
  input  logic                                 flush_valid_i,
  output logic                                 flush_ready_o,
  output logic                                 busy_o,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_write_i,
  input  logic [ADDR_WIDTH-1:0]                req_addr_i,
  input  logic [SET_COUNT-1:0]                 req_set_en_i,
  input  logic [SET_COUNT*(TAG_WIDTH+2)-1:0]   req_wtag_i,
  output logic                                 rsp_valid_o,
  output logic [SET_COUNT*(TAG_WIDTH+2)-1:0]   rsp_rtag_o
);

  localparam int unsigned WORD_WIDTH = TAG_WIDTH + 2;
  localparam int unsigned DATA_WIDTH = SET_COUNT * WORD_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(LINE_COUNT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    sweep;
  logic                    accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_o        = 1'b1;
    flush_ready_o = 1'b0;
    req_ready_o   = 1'b0;
    sweep         = 1'b0;
    case (state_q)
      S_INIT, S_FLUSH: begin
        sweep = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LINE) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        busy_o        = 1'b0;
        flush_ready_o = flush_valid_i;
        req_ready_o   = ~flush_valid_i;
        if (flush_valid_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept = req_valid_i & req_ready_o;

  // The sweep owns every SRAM port while busy; requests are never accepted then.
  logic [SET_COUNT-1:0]  sram_req;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  assign sram_req   = sweep ? {SET_COUNT{1'b1}} : ({SET_COUNT{accept}} & req_set_en_i);
  assign sram_we    = sweep | req_write_i;
  assign sram_addr  = sweep ? cnt_q : req_addr_i;
  assign sram_wdata = sweep ? '0 : req_wtag_i;

  for (genvar w = 0; w < SET_COUNT; w++) begin : g_way
    snitch_icache_tag_sram #(
      .WIDTH      (WORD_WIDTH),
      .DEPTH      (LINE_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH),
      .cfg_t      (sram_cfg_tag_t)
    ) i_sram (
      .clk   (clk_i),
      .req   (sram_req[w]),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (sram_wdata[w*WORD_WIDTH +: WORD_WIDTH]),
      .cfg   (sram_cfg_tag_i),
      .rdata (sram_rdata[w*WORD_WIDTH +: WORD_WIDTH])
    );
  end

  logic                  rd_valid_q;
  logic [SET_COUNT-1:0]  rd_en_q;
  logic                  rd_accept;

  assign rd_accept = accept & ~req_write_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_en_q    <= '0;
    end else begin
      rd_valid_q <= rd_accept;
      rd_en_q    <= rd_accept ? req_set_en_i : '0;
    end
  end

  // Disabled ways were not accessed, so their SRAM output is stale and must be hidden.
  logic [DATA_WIDTH-1:0] rd_masked;

  always_comb begin
    rd_masked = '0;
    for (int w = 0; w < SET_COUNT; w++) begin
      if (rd_en_q[w]) begin
        rd_masked[w*WORD_WIDTH +: WORD_WIDTH] = sram_rdata[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= rd_valid_q;
        out_data_q  <= rd_masked;
      end
    end

    assign rsp_valid_o = out_valid_q;
    assign rsp_rtag_o  = out_data_q;
  end else begin : g_out_direct
    assign rsp_valid_o = rd_valid_q;
    assign rsp_rtag_o  = rd_masked;
  end

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// tb/tb_snitch_icache_tag_ctrl.sv - bench for snitch_icache_tag_ctrl, with and without the output register
module tb_snitch_icache_tag_ctrl;

  localparam int SETS  = 2;
  localparam int LINES = 128;
  localparam int W     = 39;
  localparam int AW    = 7;
  localparam int DW    = SETS * W;

  localparam logic [DW-1:0] TAGS5 = {39'h3_0000_0002, 39'h2_0000_0001};
  localparam logic [DW-1:0] TAGS9 = {39'h5_A5A5_A5A5, 39'h7F_FFFF_FFFF};
  localparam logic [DW-1:0] TAGS7 = {39'h1_2345_6789, 39'h0_0BAD_F00D};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            cfg;
  logic            flush_valid;
  logic            req_valid;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [SETS-1:0] req_set_en;
  logic [DW-1:0]   req_wtag;

  logic fr0, busy0, rr0, rv0;
  logic fr1, busy1, rr1, rv1;
  logic [DW-1:0] rt0, rt1;

  snitch_icache_tag_ctrl #(
    .SET_COUNT(SETS), .LINE_COUNT(LINES), .TAG_WIDTH(37), .OUT_REG(1'b0)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .sram_cfg_tag_i(cfg),
    .flush_valid_i(flush_valid), .flush_ready_o(fr0), .busy_o(busy0),
    .req_valid_i(req_valid), .req_ready_o(rr0), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_set_en_i(req_set_en), .req_wtag_i(req_wtag),
    .rsp_valid_o(rv0), .rsp_rtag_o(rt0)
  );

  snitch_icache_tag_ctrl #(
    .SET_COUNT(SETS), .LINE_COUNT(LINES), .TAG_WIDTH(37), .OUT_REG(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sram_cfg_tag_i(cfg),
    .flush_valid_i(flush_valid), .flush_ready_o(fr1), .busy_o(busy1),
    .req_valid_i(req_valid), .req_ready_o(rr1), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_set_en_i(req_set_en), .req_wtag_i(req_wtag),
    .rsp_valid_o(rv1), .rsp_rtag_o(rt1)
  );

  int checks;
  int errors;
  int busy_seen;
  int cyc;

  // Model: 0 = INIT, 1 = IDLE, 2 = FLUSH
  int            m_mode;
  int            m_cnt;
  logic [W-1:0]  m_mem [SETS][LINES];
  logic          rd_vld [4];
  int            rd_cyc [4];
  logic [DW-1:0] rd_data [4];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) rd_vld[i] = 1'b0;
  endtask

  task automatic exp_rsp(input int lat, output logic v, output logic [DW-1:0] d);
    int t;
    int idx;
    t   = cyc - lat;
    idx = t & 3;
    v   = (t >= 0) && rd_vld[idx] && (rd_cyc[idx] == t);
    d   = rd_data[idx];
  endtask

  task automatic compare_all();
    logic          idle;
    logic          v;
    logic [DW-1:0] d;
    idle = (m_mode == 1);
    chk1("busy0", busy0, !idle);
    chk1("busy1", busy1, !idle);
    chk1("flush_ready0", fr0, idle && flush_valid);
    chk1("flush_ready1", fr1, idle && flush_valid);
    chk1("req_ready0", rr0, idle && !flush_valid);
    chk1("req_ready1", rr1, idle && !flush_valid);
    exp_rsp(1, v, d);
    chk1("rsp_valid0", rv0, v);
    if (v) chkw("rsp_rtag0", rt0, d);
    exp_rsp(2, v, d);
    chk1("rsp_valid1", rv1, v);
    if (v) chkw("rsp_rtag1", rt1, d);
    if (busy0) busy_seen++;
  endtask

  task automatic model_update();
    int            idx;
    logic [DW-1:0] d;
    if (m_mode != 1) begin
      for (int w = 0; w < SETS; w++) m_mem[w][m_cnt] = '0;
      if (m_cnt == LINES - 1) begin
        m_mode = 1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else if (flush_valid) begin
      m_mode = 2;
      m_cnt  = 0;
    end else if (req_valid) begin
      if (req_write) begin
        for (int w = 0; w < SETS; w++)
          if (req_set_en[w]) m_mem[w][req_addr] = req_wtag[w*W +: W];
      end else begin
        idx = cyc & 3;
        d   = '0;
        for (int w = 0; w < SETS; w++)
          if (req_set_en[w]) d[w*W +: W] = m_mem[w][req_addr];
        rd_vld[idx]  = 1'b1;
        rd_cyc[idx]  = cyc;
        rd_data[idx] = d;
      end
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    flush_valid = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_set_en  = '0;
    req_wtag    = '0;
  endtask

  task automatic issue(input logic wr, input int addr, input logic [SETS-1:0] en, input logic [DW-1:0] data);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = AW'(addr);
    req_set_en = en;
    req_wtag   = data;
    step();
  endtask

  task automatic run_sweep_count(input string name);
    busy_seen = 0;
    for (int i = 0; i < 130; i++) step();
    chki(name, busy_seen, LINES);
  endtask

  initial begin
    checks = 0; errors = 0; busy_seen = 0; cyc = 0;
    cfg = 1'b0;
    set_idle();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_busy", busy0, 1'b1);
    chk1("rst_req_ready", rr0, 1'b0);
    chk1("rst_flush_ready", fr0, 1'b0);
    chk1("rst_rsp_valid", rv1, 1'b0);
    chkw("rst_rsp_rtag", rt1, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // INIT sweep, with a write held on the port that must be ignored
    busy_seen = 0;
    for (int i = 0; i < 130; i++) begin
      if (i < 120) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd3;
        req_set_en = 2'b11; req_wtag = '1;
      end else begin
        set_idle();
      end
      step();
    end
    chki("init_len", busy_seen, LINES);

    for (int a = 0; a < LINES; a++) issue(1'b0, a, 2'b11, '0);
    set_idle(); step(); step();

    // write then back-to-back read of addr 5
    issue(1'b1, 5, 2'b11, TAGS5);
    issue(1'b0, 5, 2'b11, '0);
    set_idle();
    chk1("rd5_valid0", rv0, 1'b1);
    chkw("rd5_data0", rt0, TAGS5);
    chk1("rd5_valid1_early", rv1, 1'b0);
    step();
    chk1("rd5_valid1", rv1, 1'b1);
    chkw("rd5_data1", rt1, TAGS5);
    step();

    // way1-only write, masked reads
    issue(1'b1, 9, 2'b10, TAGS9);
    issue(1'b0, 9, 2'b01, '0);
    set_idle();
    chk1("rd9_mask_valid", rv0, 1'b1);
    chkw("rd9_mask_data", rt0, '0);
    step(); step();
    issue(1'b0, 9, 2'b11, '0);
    set_idle();
    chkw("rd9_full_data", rt0, {39'h5_A5A5_A5A5, 39'h0});
    step(); step();
    issue(1'b0, 9, 2'b00, '0);
    set_idle();
    chk1("rd_noen_valid", rv0, 1'b1);
    chkw("rd_noen_data", rt0, '0);
    step(); step();

    // read just before a flush that collides with a request
    issue(1'b0, 5, 2'b11, '0);
    flush_valid = 1'b1; req_valid = 1'b1; req_write = 1'b0;
    req_addr = 7'd9; req_set_en = 2'b11;
    #1;
    chk1("hs_flush_ready", fr0, 1'b1);
    chk1("hs_req_ready", rr0, 1'b0);
    chkw("hs_rsp_data0", rt0, TAGS5);
    step();
    set_idle();
    chk1("pre_flush_valid1", rv1, 1'b1);
    chkw("pre_flush_data1", rt1, TAGS5);
    run_sweep_count("flush_len");
    issue(1'b0, 5, 2'b11, '0);
    set_idle();
    chk1("post_flush_valid", rv0, 1'b1);
    chkw("post_flush_data", rt0, '0);
    step(); step();

    // flush held during a sweep is accepted again once idle
    busy_seen = 0;
    flush_valid = 1'b1;
    for (int i = 0; i < 140; i++) step();
    flush_valid = 1'b0;
    for (int i = 0; i < 200 && m_mode != 1; i++) step();
    chk1("second_sweep_done", busy0, 1'b0);
    chki("double_sweep", busy_seen, 2 * LINES);
    step();

    // reset with a read in flight
    issue(1'b1, 7, 2'b11, TAGS7);
    issue(1'b0, 7, 2'b11, '0);
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk1("rst_rd_valid0", rv0, 1'b0);
    chk1("rst_rd_valid1", rv1, 1'b0);
    chk1("rst_rd_busy", busy0, 1'b1);
    @(negedge clk); #1;
    chk1("rst_rd_valid1_late", rv1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep_count("reinit_len");

    // reset in the middle of a flush sweep
    flush_valid = 1'b1;
    step();
    set_idle();
    for (int i = 0; i < 200 && !(m_mode == 2 && m_cnt == 60); i++) step();
    chki("sweep_at_60", m_cnt, 60);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk1("rst60_valid0", rv0, 1'b0);
    chk1("rst60_req_ready", rr0, 1'b0);
    chk1("rst60_busy", busy1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep_count("reinit60_len");
    issue(1'b0, 7, 2'b11, '0);
    set_idle();
    chkw("rd7_after_reinit", rt0, '0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
